// File: rtl/servant_uart_loader.sv
// Boot loader: receives a length-prefixed RAM image over an 8N1 UART and
// writes it word by word into the servant RAM through its Wishbone slave
// port, holding the CPU in reset until the image is complete.
module servant_uart_loader #(
  parameter int depth        = 256,
  parameter int aw           = $clog2(depth),
  parameter int clks_per_bit = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_rx,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic          o_err
);

  localparam int            CW   = $clog2(clks_per_bit);
  localparam logic [CW-1:0] FULL = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] HALF = CW'(clks_per_bit / 2 - 1);
  localparam logic [15:0]   MAXW = 16'(depth / 4);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_LEN0, LD_LEN1, LD_DATA, LD_WRITE, LD_DONE, LD_ERR
  } ld_state_t;

  rx_state_t     rx_state, rx_next;
  ld_state_t     ld_state, ld_next;

  logic          rx_q1, rx_q2, rx_q3;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          rx_stb, rx_ferr;

  logic [15:0]   count;
  logic [aw-3:0] idx;
  logic [31:0]   word;
  logic [1:0]    bcnt;
  logic          hold_vld;
  logic [7:0]    hold_byte;
  logic          ferr_pend;

  logic          rx_fall, tick_half, tick_full;
  logic          byte_vld, last_word;
  logic [7:0]    byte_in;
  logic [15:0]   cand;

  assign rx_fall   = rx_q3 & ~rx_q2;
  assign tick_half = (cnt == HALF);
  assign tick_full = (cnt == FULL);

  // A byte that arrived during a write waits in the holding register and
  // takes priority over the live strobe once the loader is back in DATA.
  assign byte_vld  = hold_vld | rx_stb;
  assign byte_in   = hold_vld ? hold_byte : shreg;
  assign cand      = {byte_in, count[7:0]};
  assign last_word = (16'(idx) + 16'd1) == count;

  // Input synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      rx_q1 <= 1'b1;
      rx_q2 <= 1'b1;
      rx_q3 <= 1'b1;
    end else begin
      rx_q1 <= i_rx;
      rx_q2 <= rx_q1;
      rx_q3 <= rx_q2;
    end
  end

  // Receiver state register
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // Receiver next-state: start detect, false-start reject, 8 data bits, stop
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_q2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bitn == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver bit timing, shift register and one-cycle byte/framing strobes
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      cnt     <= '0;
      bitn    <= '0;
      shreg   <= '0;
      rx_stb  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_stb  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_START: cnt <= tick_half ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (tick_full) begin
            cnt   <= '0;
            shreg <= {rx_q2, shreg[7:1]};
            bitn  <= bitn + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            cnt     <= '0;
            rx_stb  <= rx_q2;
            rx_ferr <= ~rx_q2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt  <= '0;
          bitn <= '0;
        end
      endcase
    end
  end

  // Loader state register
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) ld_state <= LD_LEN0;
    else          ld_state <= ld_next;
  end

  // Loader next-state: length header, word assembly, bus write, terminal states
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_LEN0: begin
        if (rx_ferr)       ld_next = LD_ERR;
        else if (byte_vld) ld_next = LD_LEN1;
      end
      LD_LEN1: begin
        if (rx_ferr) ld_next = LD_ERR;
        else if (byte_vld) begin
          if (cand == 16'd0)     ld_next = LD_DONE;
          else if (cand > MAXW)  ld_next = LD_ERR;
          else                   ld_next = LD_DATA;
        end
      end
      LD_DATA: begin
        if (rx_ferr)                         ld_next = LD_ERR;
        else if (byte_vld && bcnt == 2'd3)   ld_next = LD_WRITE;
      end
      LD_WRITE: begin
        if (i_wb_ack) begin
          if (rx_ferr || ferr_pend) ld_next = LD_ERR;
          else if (last_word)       ld_next = LD_DONE;
          else                      ld_next = LD_DATA;
        end
      end
      LD_DONE: ld_next = LD_DONE;
      LD_ERR:  ld_next = LD_ERR;
      default: ld_next = LD_ERR;
    endcase
  end

  // Loader datapath: word count, little-endian assembly, holding byte, index
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      count     <= '0;
      idx       <= '0;
      word      <= '0;
      bcnt      <= '0;
      hold_vld  <= 1'b0;
      hold_byte <= '0;
      ferr_pend <= 1'b0;
    end else begin
      case (ld_state)
        LD_LEN0: if (byte_vld) count[7:0]  <= byte_in;
        LD_LEN1: if (byte_vld) count[15:8] <= byte_in;
        LD_DATA: begin
          if (byte_vld) begin
            word <= {byte_in, word[31:8]};
            bcnt <= bcnt + 1'b1;
          end
          hold_vld <= hold_vld & rx_stb;
          if (rx_stb) hold_byte <= shreg;
        end
        LD_WRITE: begin
          if (rx_stb) begin
            hold_vld  <= 1'b1;
            hold_byte <= shreg;
          end
          if (rx_ferr)  ferr_pend <= 1'b1;
          if (i_wb_ack) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_wb_cyc  = (ld_state == LD_WRITE);
  assign o_wb_we   = o_wb_cyc;
  assign o_wb_sel  = {4{o_wb_cyc}};
  assign o_wb_adr  = idx;
  assign o_wb_dat  = word;
  assign o_done    = (ld_state == LD_DONE);
  assign o_err     = (ld_state == LD_ERR);
  assign o_cpu_rst = (ld_state != LD_DONE);

endmodule
